// File: rtl/uart_replay_buffer.sv
// uart_replay_buffer
//   Captures bytes arriving on a UART receive line into an internal buffer and,
//   on request, replays the stored bytes in order on the UART transmit line.
//
//   Optional feature: define UART_REPLAY_PARITY_EN to add an even parity bit
//   after the data bits in both directions (received parity mismatches are
//   dropped and raise frame_err).
//
//   Ports
//     sys_clk    : sole clock, rising edge
//     sys_rst    : asynchronous active-high reset
//     uart_rx    : asynchronous serial input, idle high
//     uart_tx    : registered serial output, idle high
//     send       : level; a rising edge starts a replay of the stored bytes
//     clear      : empties the buffer and clears flags (ignored while busy)
//     busy       : replay in progress
//     count      : number of stored bytes, 0..DEPTH
//     overflow   : sticky, a good byte was dropped because the buffer was full
//     frame_err  : sticky, a byte was dropped for a bad stop (or parity) bit
module uart_replay_buffer #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 1024,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic        send,
  input  logic        clear,
  output logic        busy,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_REPLAY_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_REPLAY_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  // synchroniser
  logic rx_meta_q, rx_sync_q;

  // receive path
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_done;

  // buffer bookkeeping
  logic [AW:0] count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        frame_err_q, frame_err_d;
  logic        wr_en;

  // transmit path
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [AW-1:0]        tx_idx_q, tx_idx_d;
  logic [AW:0]          tx_len_q, tx_len_d;
  logic                 busy_q, busy_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 send_prev_q;
`ifdef UART_REPLAY_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  // buffer storage with registered read
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[count_q[AW-1:0]] <= rx_shift_q;
    rd_data_q <= mem[tx_idx_q];
  end

  // ---------------- receive FSM ----------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // mid-start resample filters short low glitches
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
`ifdef UART_REPLAY_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`ifdef UART_REPLAY_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_sync_q != (^rx_shift_q);
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- buffer count and flags ----------------
  // clear beats a simultaneous frame completion: that byte is simply lost
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    wr_en       = 1'b0;
    if (clear && !busy_q) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end else if (rx_done) begin
      if (!rx_sync_q || rx_perr_q) begin
        frame_err_d = 1'b1;
      end else if (count_q == FULL) begin
        overflow_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + 1'b1;
      end
    end
  end

  // ---------------- transmit FSM ----------------
  // uart_tx is a registered decode of the current state, so the line trails
  // the state by one cycle while every bit still lasts CLKS_PER_BIT cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_len_d   = tx_len_q;
    busy_d     = busy_q;
    uart_tx_d  = 1'b1;
`ifdef UART_REPLAY_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        if (send && !send_prev_q && count_q != '0) begin
          tx_state_d = TX_START;
          tx_len_d   = count_q;
          tx_idx_d   = '0;
          tx_cnt_d   = '0;
          busy_d     = 1'b1;
        end
      end
      TX_START: begin
        uart_tx_d = 1'b0;
        // rd_data_q has settled on mem[tx_idx_q] well before the start bit ends
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_shift_d = rd_data_q;
`ifdef UART_REPLAY_PARITY_EN
          tx_par_d   = ^rd_data_q;
`endif
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        uart_tx_d = tx_shift_q[0];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DATA_LAST) begin
`ifdef UART_REPLAY_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
`ifdef UART_REPLAY_PARITY_EN
      TX_PARITY: begin
        uart_tx_d = tx_par_q;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        uart_tx_d = 1'b1;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if ({1'b0, tx_idx_q} == tx_len_q - 1'b1) begin
            tx_state_d = TX_IDLE;
            busy_d     = 1'b0;
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_state_d = TX_START;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_perr_q   <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_idx_q    <= '0;
      tx_len_q    <= '0;
      busy_q      <= 1'b0;
      uart_tx_q   <= 1'b1;
      send_prev_q <= 1'b0;
`ifdef UART_REPLAY_PARITY_EN
      tx_par_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_perr_q   <= rx_perr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_idx_q    <= tx_idx_d;
      tx_len_q    <= tx_len_d;
      busy_q      <= busy_d;
      uart_tx_q   <= uart_tx_d;
      send_prev_q <= send;
`ifdef UART_REPLAY_PARITY_EN
      tx_par_q    <= tx_par_d;
`endif
    end
  end

  assign uart_tx   = uart_tx_q;
  assign busy      = busy_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
